axi4_stream_reader_v3: RTL and testbench
========================================

AXI4_STREAM_READER_V3 -- requirements
Module: axi4_stream_reader_v3

Interface
REQ-001 Parameter C_S_AXIS_TDATA_WIDTH, default 32, TDATA and data width in bits; multiple of 8, minimum 8.
REQ-002 Parameter C_FIFO_DEPTH_LOG2, default 4, FIFO depth = 2**C_FIFO_DEPTH_LOG2 entries; minimum 1.
REQ-003 S_AXIS_ACLK  input  1  sole clock; all state updates on rising edge.
REQ-004 S_AXIS_ARESET  input  1  synchronous, active-high reset.
REQ-005 S_AXIS_TREADY  output  1  slave ready; high when FIFO not full and not in reset.
REQ-006 S_AXIS_TDATA  input  C_S_AXIS_TDATA_WIDTH  stream data.
REQ-007 S_AXIS_TSTRB  input  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers, stored with data.
REQ-008 S_AXIS_TLAST  input  1  end of packet, stored with data.
REQ-009 S_AXIS_TVALID  input  1  master valid.
REQ-010 ready  input  1  consumer pop request; pops head when data_valid high.
REQ-011 data_valid  output  1  FIFO head valid (FIFO not empty).
REQ-012 data  output  C_S_AXIS_TDATA_WIDTH  head data.
REQ-013 data_strb  output  C_S_AXIS_TDATA_WIDTH/8  head TSTRB.
REQ-014 data_last  output  1  head TLAST.
REQ-015 level  output  C_FIFO_DEPTH_LOG2+1  current occupancy, 0..depth.
REQ-016 packet_count  output  16  count of popped words with data_last high.

Function
REQ-017 Write occurs on an edge where S_AXIS_TVALID and S_AXIS_TREADY are both high; {TDATA, TSTRB, TLAST} stored at write pointer.
REQ-018 S_AXIS_TREADY is a registered output: high iff level < depth after the current edge's update; no combinational path from TVALID or ready.
REQ-019 Pop occurs on an edge where ready and data_valid are both high; ready with data_valid low is ignored.
REQ-020 First-word-fall-through: data, data_strb, data_last show head entry whenever data_valid is high; no read latency.
REQ-021 Write-to-output latency: word written at edge N appears on data with data_valid high after edge N (cycle N+1) if FIFO was empty.
REQ-022 No same-cycle bypass: a word written at edge N is never popped at edge N.
REQ-023 Simultaneous write and pop: level unchanged, both pointers advance.
REQ-024 Full (level = depth): TREADY low, no write; a pop at edge N raises TREADY after edge N.
REQ-025 Empty (level = 0): data_valid low; data/data_strb/data_last are don't-care.
REQ-026 Read and write pointers are C_FIFO_DEPTH_LOG2 bits and wrap modulo depth; level never exceeds depth nor underflows.
REQ-027 packet_count increments by 1 on each pop with data_last high; wraps 0xFFFF -> 0x0000.
REQ-028 Order preserved: words leave in acceptance order with their TSTRB/TLAST unchanged.

Reset
REQ-029 While S_AXIS_ARESET is high at an edge: pointers = 0, level = 0, packet_count = 0, data_valid = 0, S_AXIS_TREADY = 0.
REQ-030 Reset mid-operation discards all stored words; no partial packet is reported afterwards.
REQ-031 First edge with S_AXIS_ARESET low sets S_AXIS_TREADY = 1; writes accepted from the following edge.
REQ-032 Storage array is not reset; only control state is.

Verification (C_FIFO_DEPTH_LOG2 = 2, depth 4, width 32)
REQ-033 Single word: after reset push 0xA5A5A5A5, TSTRB 0xF, TLAST 1, ready 0 -> next cycle data_valid 1, data 0xA5A5A5A5, data_last 1, level 1; pulse ready -> data_valid 0, packet_count 1.
REQ-034 Fill: TVALID held high, ready 0, data 1,2,3,4,5 -> 4 accepted, TREADY low after 4th, level 4, word 5 held by master; one pop -> data 1 leaves, TREADY 1, word 5 accepted next edge.
REQ-035 Concurrent: level 2, TVALID and ready high for 10 cycles with incrementing data -> level stays 2, output sequence strictly incrementing, pointers wrap without loss.
REQ-036 Packets: 3 packets of lengths 1, 3, 2 with random ready/TVALID stalls -> packet_count 3 at end, data_last high exactly on words 1, 4, 6.
REQ-037 Reset mid-stream: level 3, assert S_AXIS_ARESET one cycle -> level 0, data_valid 0, TREADY 0 that cycle, TREADY 1 next, packet_count 0.
REQ-038 Strobe: push TSTRB 0x3 then 0xC -> data_strb shows 0x3 then 0xC on successive pops.

Source files
------------

// File: rtl/axi4_stream_reader_v3_if.sv
// AXI4-Stream slave-side bundle for the stream reader FIFO.
// The master drives the payload and TVALID; the slave answers with TREADY.
interface axi4_stream_reader_v3_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);
  logic                                S_AXIS_TREADY;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA;
  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB;
  logic                                S_AXIS_TLAST;
  logic                                S_AXIS_TVALID;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/axi4_stream_reader_v3.sv
// AXI4-Stream slave feeding a first-word-fall-through FIFO with a simple pop interface.
// Also counts popped end-of-packet words.
module axi4_stream_reader_v3 #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH_LOG2    = 4
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  axi4_stream_reader_v3_if.slave              s_axis,
  input  logic                                ready,
  output logic                                data_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     data,
  output logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] data_strb,
  output logic                                data_last,
  output logic [C_FIFO_DEPTH_LOG2:0]          level,
  output logic [15:0]                         packet_count
);

  localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** C_FIFO_DEPTH_LOG2;
  localparam int PTR_W  = C_FIFO_DEPTH_LOG2;
  localparam int LVL_W  = C_FIFO_DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [C_S_AXIS_TDATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [STRB_W-1:0]               mem_strb_q [DEPTH];
  logic                            mem_last_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      packet_count_q, packet_count_d;
  logic             tready_q, tready_d;
  logic             wr_en;
  logic             pop_en;

  // Pop only sees what was stored before this edge, so a fresh word cannot bypass.
  always_comb begin
    wr_en          = s_axis.S_AXIS_TVALID && tready_q;
    pop_en         = ready && (level_q != '0);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    packet_count_d = packet_count_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (mem_last_q[rd_ptr_q]) begin
        packet_count_d = packet_count_q + 16'd1;
      end
    end

    case ({wr_en, pop_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    tready_d = (level_d < DEPTH_LVL);
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      packet_count_q <= '0;
      tready_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      packet_count_q <= packet_count_d;
      tready_q       <= tready_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= s_axis.S_AXIS_TDATA;
      mem_strb_q[wr_ptr_q] <= s_axis.S_AXIS_TSTRB;
      mem_last_q[wr_ptr_q] <= s_axis.S_AXIS_TLAST;
    end
  end

  assign s_axis.S_AXIS_TREADY = tready_q;
  assign data_valid           = (level_q != '0);
  assign data                 = mem_data_q[rd_ptr_q];
  assign data_strb            = mem_strb_q[rd_ptr_q];
  assign data_last            = mem_last_q[rd_ptr_q];
  assign level                = level_q;
  assign packet_count         = packet_count_q;

endmodule

// File: tb/tb_axi4_stream_reader_v3.sv
// Scoreboard bench for axi4_stream_reader_v3 at depth 4, width 32.
// Accepted words are queued and compared against the FIFO head every cycle and on each pop.
module tb_axi4_stream_reader_v3;

  localparam int W = 32;
  localparam int LOG2 = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   s;
    logic         l;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          ready;
  logic          data_valid;
  logic [W-1:0]  data;
  logic [3:0]    data_strb;
  logic          data_last;
  logic [LOG2:0] level;
  logic [15:0]   packet_count;

  axi4_stream_reader_v3_if #(.C_S_AXIS_TDATA_WIDTH(W)) axis ();

  axi4_stream_reader_v3 #(
    .C_S_AXIS_TDATA_WIDTH(W),
    .C_FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .s_axis(axis),
    .ready(ready),
    .data_valid(data_valid),
    .data(data),
    .data_strb(data_strb),
    .data_last(data_last),
    .level(level),
    .packet_count(packet_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  entry_t      sb_q[$];
  bit          model_tready = 1'b0;
  logic [15:0] model_pc = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check registered outputs, then advance the model.
  task automatic applyStimulus(input bit tv, input logic [W-1:0] td, input logic [3:0] ts,
                               input bit tl, input bit rdy, output bit acc);
    bit     wr;
    bit     pop;
    entry_t head;
    int     lvl;
    @(negedge clk);
    rst                = 1'b0;
    axis.S_AXIS_TVALID = tv;
    axis.S_AXIS_TDATA  = td;
    axis.S_AXIS_TSTRB  = ts;
    axis.S_AXIS_TLAST  = tl;
    ready              = rdy;
    lvl = sb_q.size();
    checkOutput("tready", 64'(axis.S_AXIS_TREADY), 64'(model_tready));
    checkOutput("data_valid", 64'(data_valid), 64'(lvl != 0));
    checkOutput("level", 64'(level), 64'(lvl));
    checkOutput("packet_count", 64'(packet_count), 64'(model_pc));
    if (lvl != 0) begin
      head = sb_q[0];
      checkOutput("head_data", 64'(data), 64'(head.d));
      checkOutput("head_strb", 64'(data_strb), 64'(head.s));
      checkOutput("head_last", 64'(data_last), 64'(head.l));
    end
    wr  = tv && model_tready;
    pop = rdy && (lvl != 0);
    if (pop) begin
      head = sb_q.pop_front();
      if (head.l) model_pc = model_pc + 16'd1;
    end
    if (wr) sb_q.push_back('{d: td, s: ts, l: tl});
    model_tready = (sb_q.size() < DEPTH);
    acc = wr;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst                = 1'b1;
    axis.S_AXIS_TVALID = 1'b0;
    ready              = 1'b0;
    @(posedge clk);
    sb_q.delete();
    model_pc     = '0;
    model_tready = 1'b0;
  endtask

  task automatic sendWord(input logic [W-1:0] td, input logic [3:0] ts, input bit tl, input bit rdy);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      applyStimulus(1'b1, td, ts, tl, rdy, acc);
    end
  endtask

  task automatic drainAll();
    bit acc;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    int          idx;
    bit          tv;
    bit          rdy;
    logic [3:0]  pkt_strb;
    bit          pkt_last [6];
    rst                = 1'b1;
    ready              = 1'b0;
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TDATA  = '0;
    axis.S_AXIS_TSTRB  = '0;
    axis.S_AXIS_TLAST  = 1'b0;
    applyReset();
    applyReset();

    // Reset state and first write opportunity, then single-word packet.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
    sendWord(32'hA5A5A5A5, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Fill to full; word 5 is held until a pop frees a slot.
    for (int i = 1; i <= 4; i++) sendWord(W'(i), 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd5, 4'hF, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'd5, 4'hF, 1'b0, 1'b1, acc);
    sendWord(32'd5, 4'hF, 1'b0, 1'b0);

    // Drop to level 2, then stream and pop concurrently across pointer wrap.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, W'(100 + i), 4'hF, 1'b0, 1'b1, acc);
    drainAll();

    // Strobe pass-through.
    sendWord(32'h11, 4'h3, 1'b0, 1'b0);
    sendWord(32'h22, 4'hC, 1'b0, 1'b0);
    drainAll();

    // Reset with three words stored.
    for (int i = 0; i < 3; i++) sendWord(W'(200 + i), 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
    applyReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Packets of length 1, 3, 2 with random stalls on both sides.
    pkt_last = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idx = 0;
    for (int c = 0; c < 300 && idx < 6; c++) begin
      tv       = ($urandom_range(0, 3) != 0);
      rdy      = ($urandom_range(0, 1) != 0);
      pkt_strb = 4'($urandom_range(0, 15));
      applyStimulus(tv, W'(32'h1000 + idx), pkt_strb, pkt_last[idx], rdy, acc);
      if (acc) idx++;
    end
    checkOutput("pkt_words_sent", 64'(idx), 64'd6);
    drainAll();
    @(negedge clk);
    checkOutput("pkt_total", 64'(packet_count), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
